// File: rtl/mc_main_control.sv
// mc_main_control: multi-cycle MIPS main control FSM with memory wait states and a timeout watchdog
// Optional feature: define MC_ADDI_EN to add ADDI (opcode 001000) through states ADDIEX=10 and ADDIWB=11.
// Ports: clk, rst (synchronous, active-high); opcode, zero, mem_ready in;
//        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
//        reg_write, alu_src_a, alu_src_b, pc_source, aluop out; state (debug), fault (sticky) out.
module mc_main_control #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [1:0] aluop,
    output logic [3:0] state,
    output logic       fault
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
`ifdef MC_ADDI_EN
        ADDIEX = 4'd10,
        ADDIWB = 4'd11,
`endif
        HALT   = 4'd15
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] aluop;
    } ctl_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
`ifdef MC_ADDI_EN
    localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

    state_t           st, nxt;
    ctl_t             ctl;
    logic [CNT_W-1:0] cnt;
    logic             in_fetch, timeout, wait_st;
    logic             unused_zero;

    // The zero flag gates pc_write_cond in the datapath, not here.
    assign unused_zero = zero;

    function automatic ctl_t dec(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
            DECODE: c.alu_src_b = 2'b11;
            MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            MEMRD:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
            MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            MEMWR:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
            EXEC:   begin c.alu_src_a = 1'b1; c.aluop = 2'b10; end
            RWB:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            BRANCH: begin c.alu_src_a = 1'b1; c.aluop = 2'b01; c.pc_write_cond = 1'b1; c.pc_source = 2'b01; end
            JUMP:   begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
`ifdef MC_ADDI_EN
            ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            ADDIWB: c.reg_write = 1'b1;
`endif
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        timeout = cnt == CNT_W'(TIMEOUT_CYCLES);
        wait_st = st == FETCH || st == MEMRD || st == MEMWR;
        nxt = st;
        case (st)
            FETCH:  nxt = mem_ready ? DECODE : timeout ? HALT : FETCH;
            DECODE: begin
                nxt = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                      opcode == OP_R   ? EXEC   :
                      opcode == OP_BEQ ? BRANCH :
                      opcode == OP_J   ? JUMP   : HALT;
`ifdef MC_ADDI_EN
                if (opcode == OP_ADDI) nxt = ADDIEX;
`endif
            end
            MEMADR: nxt = opcode == OP_SW ? MEMWR : MEMRD;
            MEMRD:  nxt = mem_ready ? MEMWB : timeout ? HALT : MEMRD;
            MEMWR:  nxt = mem_ready ? FETCH : timeout ? HALT : MEMWR;
            EXEC:   nxt = RWB;
`ifdef MC_ADDI_EN
            ADDIEX: nxt = ADDIWB;
`endif
            HALT:   nxt = HALT;
            default: nxt = FETCH;
        endcase
    end

    // Outputs are registered from the next state, so they line up with the state they decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= FETCH;
            cnt      <= '0;
            fault    <= 1'b0;
            ctl      <= dec(FETCH);
            in_fetch <= 1'b1;
        end else begin
            st       <= nxt;
            cnt      <= (wait_st && nxt == st && !mem_ready) ? cnt + 1'b1 : '0;
            fault    <= fault || nxt == HALT;
            ctl      <= dec(nxt);
            in_fetch <= nxt == FETCH;
        end
    end

    // Fetch completion loads IR and PC in the same cycle the memory answers.
    assign ir_write      = in_fetch & mem_ready;
    assign pc_write      = ctl.pc_write | (in_fetch & mem_ready);
    assign pc_write_cond = ctl.pc_write_cond;
    assign iord          = ctl.iord;
    assign mem_read      = ctl.mem_read;
    assign mem_write     = ctl.mem_write;
    assign mem_to_reg    = ctl.mem_to_reg;
    assign reg_dst       = ctl.reg_dst;
    assign reg_write     = ctl.reg_write;
    assign alu_src_a     = ctl.alu_src_a;
    assign alu_src_b     = ctl.alu_src_b;
    assign pc_source     = ctl.pc_source;
    assign aluop         = ctl.aluop;
    assign state         = st;
endmodule

// File: tb/tb_mc_main_control.sv
// tb_mc_main_control: self-checking bench for mc_main_control (reference model plus directed and random stimulus)
module tb_mc_main_control;
    localparam int T = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, fault;
    logic [1:0] alu_src_b, pc_source, aluop;
    logic [3:0] state;

    int checks = 0;
    int fails = 0;

    int m = 0;
    int stall = 0;
    bit mf = 1'b0;

    int es[$];
    bit rs[$];
    int o_al[$], o_rw[$], o_rd[$], o_m2r[$], o_mr[$], o_io[$], o_pwc[$], o_ps[$];

    always #5 clk = ~clk;

    mc_main_control #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .aluop(aluop), .state(state), .fault(fault)
    );

    // Expected control word for a state, straight from the per-state output table.
    function automatic logic [16:0] expv(int s, logic r, logic f);
        logic pw, pwc, io, mr, mw, ir, m2r, rd, rw, a;
        logic [1:0] b, ps, op;
        {pw, pwc, io, mr, mw, ir, m2r, rd, rw, a} = '0;
        b = 2'b00;
        ps = 2'b00;
        op = 2'b00;
        case (s)
            0:  begin mr = 1; pw = r; ir = r; b = 2'b01; end
            1:  b = 2'b11;
            2:  begin a = 1; b = 2'b10; end
            3:  begin mr = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; io = 1; end
            6:  begin a = 1; op = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin a = 1; op = 2'b01; pwc = 1; ps = 2'b01; end
            9:  begin pw = 1; ps = 2'b10; end
            10: begin a = 1; b = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pw, pwc, io, mr, mw, ir, m2r, rd, rw, a, b, ps, op, f};
    endfunction

    function automatic int after_decode(logic [5:0] op);
        if (op == 6'b100011 || op == 6'b101011) return 2;
        if (op == 6'b000000) return 6;
        if (op == 6'b000100) return 8;
        if (op == 6'b000010) return 9;
`ifdef MC_ADDI_EN
        if (op == 6'b001000) return 10;
`endif
        return 15;
    endfunction

    // Compare every cycle, then advance the model to the state after the coming edge.
    always @(negedge clk) begin
        logic [16:0] ev, dv;
        int nm;
        ev = expv(m, mem_ready, mf);
        dv = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
              reg_write, alu_src_a, alu_src_b, pc_source, aluop, fault};
        checks++;
        if (dv !== ev || state !== 4'(m)) begin
            fails++;
            $display("FAIL model_cycle t=%0t state=%0d exp_state=%0d ctl=%h exp_ctl=%h", $time, state, m, dv, ev);
        end
        if (rst) begin
            m = 0;
            stall = 0;
            mf = 1'b0;
        end else begin
            case (m)
                0: nm = mem_ready ? 1 : (stall == T ? 15 : 0);
                1: nm = after_decode(opcode);
                2: nm = opcode == 6'b101011 ? 5 : 3;
                3: nm = mem_ready ? 4 : (stall == T ? 15 : 3);
                5: nm = mem_ready ? 0 : (stall == T ? 15 : 5);
                6: nm = 7;
                10: nm = 11;
                15: nm = 15;
                default: nm = 0;
            endcase
            stall = (nm == m && (m == 0 || m == 3 || m == 5) && !mem_ready) ? stall + 1 : 0;
            mf = mf || nm == 15;
            m = nm;
        end
    end

    task automatic chk(string nm, int got, int exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic run_seq(string nm, logic [5:0] op);
        o_al.delete(); o_rw.delete(); o_rd.delete(); o_m2r.delete();
        o_mr.delete(); o_io.delete(); o_pwc.delete(); o_ps.delete();
        for (int i = 0; i < es.size(); i++) begin
            mem_ready = rs[i];
            opcode = op;
            look();
            o_al.push_back(int'(aluop));
            o_rw.push_back(int'(reg_write));
            o_rd.push_back(int'(reg_dst));
            o_m2r.push_back(int'(mem_to_reg));
            o_mr.push_back(int'(mem_read));
            o_io.push_back(int'(iord));
            o_pwc.push_back(int'(pc_write_cond));
            o_ps.push_back(int'(pc_source));
            chk(nm, int'(state), es[i]);
            cyc();
        end
    endtask

    function automatic logic [5:0] pick();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0: return 6'b100011;
            1: return 6'b101011;
            2: return 6'b000000;
            3: return 6'b000100;
            4: return 6'b000010;
            5: return 6'b001000;
            default: return 6'($urandom);
        endcase
    endfunction

    initial begin
        int rp;
        do_reset();
        look();
        chk("reset_state", int'(state), 0);
        chk("reset_fault", int'(fault), 0);
        chk("reset_mem_write", int'(mem_write), 0);
        chk("reset_reg_write", int'(reg_write), 0);
        chk("reset_pc_write_cond", int'(pc_write_cond), 0);

        do_reset();
        es = '{0, 1, 6, 7, 0};
        rs = '{1, 1, 1, 1, 1};
        run_seq("rtype_seq", 6'b000000);
        chk("rtype_exec_aluop", o_al[2], 2);
        chk("rtype_exec_reg_write", o_rw[2], 0);
        chk("rtype_rwb_reg_write", o_rw[3], 1);
        chk("rtype_rwb_reg_dst", o_rd[3], 1);
        chk("rtype_decode_reg_dst", o_rd[1], 0);

        do_reset();
        es = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
        rs = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
        run_seq("lw_seq", 6'b100011);
        for (int i = 3; i <= 6; i++) begin
            chk("lw_memrd_mem_read", o_mr[i], 1);
            chk("lw_memrd_iord", o_io[i], 1);
        end
        chk("lw_memwb_reg_write", o_rw[7], 1);
        chk("lw_memwb_mem_to_reg", o_m2r[7], 1);
        chk("lw_memwb_reg_dst", o_rd[7], 0);
        chk("lw_fault", int'(fault), 0);

        for (int z = 1; z >= 0; z--) begin
            do_reset();
            zero = z[0];
            es = '{0, 1, 8, 0};
            rs = '{1, 1, 1, 1};
            run_seq("beq_seq", 6'b000100);
            chk("beq_aluop", o_al[2], 1);
            chk("beq_pc_write_cond", o_pwc[2], 1);
            chk("beq_pc_source", o_ps[2], 1);
        end

        do_reset();
        es = '{0, 1, 9, 0};
        rs = '{1, 1, 1, 1};
        run_seq("j_seq", 6'b000010);
        chk("j_pc_source", o_ps[2], 2);

        do_reset();
        es = '{0, 1, 15};
        rs = '{1, 1, 1};
        run_seq("illegal_seq", 6'b111111);
        for (int i = 0; i < 20; i++) begin
            opcode = 6'($urandom);
            mem_ready = 1'($urandom);
            zero = 1'($urandom);
            look();
            chk("halt_stays", int'(state), 15);
            chk("halt_fault", int'(fault), 1);
            cyc();
        end
        do_reset();
        look();
        chk("halt_reset_state", int'(state), 0);
        chk("halt_reset_fault", int'(fault), 0);

        do_reset();
        opcode = 6'b000000;
        for (int i = 0; i < 16; i++) begin
            mem_ready = 1'b0;
            look();
            chk("timeout_fetch_hold", int'(state), 0);
            cyc();
        end
        look();
        chk("timeout_halt", int'(state), 15);
        chk("timeout_fault", int'(fault), 1);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            mem_ready = i == 15;
            look();
            chk("late_ready_fetch_hold", int'(state), 0);
            cyc();
        end
        look();
        chk("late_ready_decode", int'(state), 1);
        chk("late_ready_fault", int'(fault), 0);

        do_reset();
        es = '{0, 1, 2, 5};
        rs = '{1, 1, 1, 0};
        run_seq("sw_seq", 6'b101011);
        rst = 1'b1;
        look();
        chk("memwr_before_rst", int'(state), 5);
        chk("memwr_mem_write", int'(mem_write), 1);
        cyc();
        rst = 1'b0;
        look();
        chk("rst_in_memwr_state", int'(state), 0);
        chk("rst_in_memwr_mem_write", int'(mem_write), 0);

        do_reset();
`ifdef MC_ADDI_EN
        es = '{0, 1, 10, 11, 0};
        rs = '{1, 1, 1, 1, 1};
        run_seq("addi_seq", 6'b001000);
        chk("addi_wb_reg_write", o_rw[3], 1);
`else
        es = '{0, 1, 15};
        rs = '{1, 1, 1};
        run_seq("addi_illegal_seq", 6'b001000);
        look();
        chk("addi_illegal_fault", int'(fault), 1);
`endif

        do_reset();
        for (int blk = 0; blk < 16; blk++) begin
            case (blk % 4)
                0: rp = 90;
                1: rp = 60;
                2: rp = 30;
                default: rp = 4;
            endcase
            for (int i = 0; i < 200; i++) begin
                rst = (m == 15 && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0;
                zero = 1'($urandom);
                mem_ready = $urandom_range(0, 99) < rp;
                if (m == 0 || m == 15) opcode = pick();
                cyc();
            end
        end
        rst = 1'b0;
        look();

        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end
endmodule

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
- Multi-cycle main control FSM for the MIPS core.
- Sequences fetch, decode, execute, memory and writeback over several cycles per instruction.
- Drives all datapath enables and mux selects, and the 2-bit aluop into the ALU control decoder.
- Inserts wait states on the shared instruction/data memory through a ready handshake, with a timeout watchdog.

Parameters:
- TIMEOUT_CYCLES, 15: max consecutive cycles waiting on mem_ready before a fault; valid range 1..255.
- CNT_W, 8: width of the wait counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  instr[31:26] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  writeback select: 1=MDR, 0=ALUOut
- reg_dst  out  1  destination register: 1=rd, 0=rt
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A: 0=PC, 1=A register
- alu_src_b  out  2  ALU B: 00=B, 01=const 4, 10=sign-extended immediate, 11=sign-extended immediate<<2
- pc_source  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
- aluop  out  2  00=add, 01=sub, 10=funct-decoded
- state  out  4  current state encoding (debug)
- fault  out  1  sticky; set on illegal opcode or memory timeout

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, HALT=15.
- Reset (synchronous, active-high):
  - state=FETCH, wait counter=0, fault=0.
  - All strobes 0; all selects 0; aluop=00.
- Outputs are Moore, decoded from state only. The only exception is the mem_ready gating on the fetch/memory advance enables, described below.
- FETCH:
  - Drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, aluop=00, pc_source=00.
  - ir_write=mem_ready and pc_write=mem_ready (combinational AND).
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, aluop=00 (branch target precompute).
  - Next state by opcode:
    - 100011 (LW) or 101011 (SW) -> MEMADR
    - 000000 (R-type) -> EXEC
    - 000100 (BEQ) -> BRANCH
    - 000010 (J) -> JUMP
    - any other opcode -> HALT with fault=1
- MEMADR: alu_src_a=1, alu_src_b=10, aluop=00. Goes to MEMRD for LW, MEMWR for SW (opcode is held by the IR).
- MEMRD: mem_read=1, iord=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, then FETCH.
- MEMWR: mem_write=1, iord=1. Waits for mem_ready, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, aluop=10, then RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, aluop=01, pc_write_cond=1, pc_source=01, then FETCH. The PC update occurs only when zero=1; gating is external.
- JUMP: pc_write=1, pc_source=10, then FETCH.
- HALT:
  - Absorbing: all strobes 0, fault=1.
  - Exited only by rst.
- Wait counter:
  - Increments each cycle in FETCH, MEMRD or MEMWR while mem_ready=0.
  - Clears on mem_ready=1 and on any state change.
  - When it reaches TIMEOUT_CYCLES with mem_ready still 0, the next state is HALT and fault is set.
  - mem_ready=1 in the same cycle the count hits TIMEOUT_CYCLES: completion wins, no fault.
- Latencies with zero wait states:
  - LW: 5 cycles
  - SW and R-type: 4 cycles
  - BEQ and J: 3 cycles
- Reset mid-instruction: rst has priority over all transitions. Any in-flight mem_read or mem_write is dropped the following cycle.

Optional Feature:
- Macro: MC_ADDI_EN.
- With the macro defined:
  - Opcode 001000 (ADDI) in DECODE -> state ADDIEX=10, which drives alu_src_a=1, alu_src_b=10, aluop=00, then goes to ADDIWB.
  - ADDIWB=11 drives reg_write=1, reg_dst=0, mem_to_reg=0, then goes to FETCH.
  - ADDI latency is 4 cycles.
- Without the macro: opcode 001000 is illegal, giving HALT with fault=1. States 10 and 11 do not exist.

Test Plan:
- Reset, then R-type (opcode 000000) with mem_ready tied 1 -> state sequence 0,1,6,7,0; aluop=10 in EXEC; reg_write=1 and reg_dst=1 only in RWB.
- LW (100011) with mem_ready low for 3 cycles in MEMRD -> MEMRD held for 4 cycles; mem_read=1 and iord=1 throughout; MEMWB asserts reg_write=1 with mem_to_reg=1; no fault.
- BEQ (000100) with zero=1, then again with zero=0 -> both runs show state sequence 0,1,8,0 with aluop=01, pc_write_cond=1 and pc_source=01 in BRANCH.
- Opcode 111111 -> HALT (state=15), fault=1; stays there for 20 cycles despite stimulus; rst returns state=0, fault=0.
- TIMEOUT_CYCLES=15 with mem_ready held 0 in FETCH -> HALT after exactly 16 cycles in FETCH. Repeat with mem_ready=1 on the 16th cycle -> DECODE, no fault.
- rst asserted while in MEMWR -> next cycle state=0, mem_write=0. With MC_ADDI_EN defined, opcode 001000 -> sequence 0,1,10,11,0; without it -> HALT with fault=1.
